// File: rtl/router_pkg.sv
// Shared widths, FSM states and the power-up memory image for the 4-lane router.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package router_pkg;

    localparam int DATA_W      = 1024;
    localparam int LANES       = 4;
    localparam int LANE_W      = 32;
    localparam int BEAT_W      = LANES * LANE_W;
    localparam int BEATS       = DATA_W / BEAT_W;
    localparam int DEPTH       = 16;
    localparam int MEM_AW      = $clog2(DEPTH);
    localparam int ADDR_W      = 10;
    localparam int INIT_CYCLES = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [MEM_AW-1:0] mem_addr_t;
    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ,
        SEND,
        WAIT_RX,
        WRITE,
        DONE
    } state_t;

    // Word k holds its own index in every 32-bit slot so transfers are traceable.
    function automatic mem_t mem_init();
        mem_t m;
        for (int k = 0; k < DEPTH; k++) begin
            m[k] = {(DATA_W/32){32'hA500_0000 | 32'(k)}};
        end
        return m;
    endfunction

endpackage

// File: rtl/router_4lane_loopback_top_lane_rx_assembler.sv
// Collects BEATS full-width lane beats into one word, lowest beat first.
// Latency: word_ready pulses the cycle after the last beat is sampled.
// Backpressure: none; a beat counts only when every lane is valid, partial beats are dropped.
module lane_rx_assembler
    import router_pkg::*;
(
    input  logic                  user_clk,
    input  logic                  rst_n,
    input  logic [BEAT_W-1:0]     rx_data,
    input  logic [LANES-1:0]      rx_valid,
    output logic [DATA_W-1:0]     word,
    output logic                  word_ready
);

    localparam logic [$clog2(BEATS)-1:0] BEAT_LAST = ($clog2(BEATS))'(BEATS - 1);

    logic [$clog2(BEATS)-1:0] beat_cnt;

    // Place each complete beat at the counter position; flag the word on the last one.
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (&rx_valid) begin
                word[BEAT_W*int'(beat_cnt) +: BEAT_W] <= rx_data;
                if (beat_cnt == BEAT_LAST) begin
                    beat_cnt   <= '0;
                    word_ready <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/router_4lane_loopback_top.sv
// Reads a word from local memory, stripes it over 4 lanes, writes the reassembled RX word back.
// Latency: start sampled at edge E, router_done rises after edge E+11 with a zero-delay loopback.
// Backpressure: starts are taken only in IDLE (router_done=1); others are dropped, never queued.
module router_4lane_loopback_top
    import router_pkg::*;
(
    input  logic                     user_clk,
    input  logic                     rst_n,
    input  logic                     router_start_req,
    input  logic [ADDR_W-1:0]        router_scr_addr,
    input  logic [ADDR_W-1:0]        router_dst_addr,
    output logic                     router_done,
    output logic [LANES*LANE_W-1:0]  lane_tx_data,
    output logic [LANES-1:0]         lane_tx_valid,
    input  logic [LANES*LANE_W-1:0]  lane_rx_data,
    input  logic [LANES-1:0]         lane_rx_valid,
    output logic [ADDR_W-1:0]        dbg_dst_addr,
    output logic [DATA_W-1:0]        dbg_data_recv
);

    localparam logic [$clog2(INIT_CYCLES)-1:0] INIT_LAST = ($clog2(INIT_CYCLES))'(INIT_CYCLES - 1);
    localparam logic [$clog2(BEATS)-1:0]       BEAT_LAST = ($clog2(BEATS))'(BEATS - 1);

    state_t                         state;
    logic [$clog2(INIT_CYCLES)-1:0] init_cnt;
    logic [$clog2(BEATS)-1:0]       beat_cnt;
    mem_addr_t                      src_q;
    addr_t                          dst_q;
    logic [DATA_W-1:0]              tx_shift;
    logic [LANES-1:0]               tx_valid;
    logic [DATA_W-1:0]              rx_word;
    logic                           word_ready;

    // Memory survives reset, so it carries its image from configuration rather than from rst_n.
    mem_t mem = mem_init();

    // Source address bits above the memory index simply wrap away.
    logic unused_src_hi;
    assign unused_src_hi = ^router_scr_addr[ADDR_W-1:MEM_AW];

    // The low beat of the shift register is what is on the wire.
    assign lane_tx_data  = tx_shift[BEAT_W-1:0];
    assign lane_tx_valid = tx_valid;

    lane_rx_assembler u_rx (
        .user_clk   (user_clk),
        .rst_n      (rst_n),
        .rx_data    (lane_rx_data),
        .rx_valid   (lane_rx_valid),
        .word       (rx_word),
        .word_ready (word_ready)
    );

    // Memory write port; reset forces the FSM out of WRITE so an aborted transfer never lands.
    always_ff @(posedge user_clk) begin
        if (state == WRITE) begin
            mem[dst_q[MEM_AW-1:0]] <= rx_word;
        end
    end

    // Transfer sequencer with registered lane and status outputs.
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            init_cnt      <= '0;
            beat_cnt      <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            tx_shift      <= '0;
            tx_valid      <= '0;
            router_done   <= 1'b0;
            dbg_dst_addr  <= '0;
            dbg_data_recv <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state       <= IDLE;
                        router_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    router_done <= 1'b1;
                    if (router_start_req) begin
                        src_q       <= router_scr_addr[MEM_AW-1:0];
                        dst_q       <= router_dst_addr;
                        router_done <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    tx_shift <= mem[src_q];
                    tx_valid <= '1;
                    beat_cnt <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (beat_cnt == BEAT_LAST) begin
                        tx_shift <= '0;
                        tx_valid <= '0;
                        state    <= WAIT_RX;
                    end else begin
                        tx_shift <= tx_shift >> BEAT_W;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                WAIT_RX: begin
                    if (word_ready) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    dbg_data_recv <= rx_word;
                    dbg_dst_addr  <= dst_q;
                    router_done   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_4lane_loopback_top.sv
// Directed bench: external lane loopback, table of transfers plus drop/abort sequences.
// Latency: checks start-to-done of 11 edges and INIT of 16 edges.
// Backpressure: exercises ignored starts and dropped partial-valid beats.
module tb_router_4lane_loopback_top;

    logic          user_clk = 1'b0;
    logic          rst_n;
    logic          router_start_req;
    logic [9:0]    router_scr_addr;
    logic [9:0]    router_dst_addr;
    logic          router_done;
    logic [127:0]  lane_tx_data;
    logic [3:0]    lane_tx_valid;
    logic [127:0]  lane_rx_data;
    logic [3:0]    lane_rx_valid;
    logic [9:0]    dbg_dst_addr;
    logic [1023:0] dbg_data_recv;

    logic          rx_override = 1'b0;
    logic [127:0]  ovr_data    = '0;
    logic [3:0]    valid_mask  = 4'hF;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 user_clk = ~user_clk;

    // External loopback standing in for the serial link, with fault injection hooks.
    assign lane_rx_data  = rx_override ? ovr_data : lane_tx_data;
    assign lane_rx_valid = rx_override ? 4'hF : (lane_tx_valid & valid_mask);

    router_4lane_loopback_top dut (
        .user_clk         (user_clk),
        .rst_n            (rst_n),
        .router_start_req (router_start_req),
        .router_scr_addr  (router_scr_addr),
        .router_dst_addr  (router_dst_addr),
        .router_done      (router_done),
        .lane_tx_data     (lane_tx_data),
        .lane_tx_valid    (lane_tx_valid),
        .lane_rx_data     (lane_rx_data),
        .lane_rx_valid    (lane_rx_valid),
        .dbg_dst_addr     (dbg_dst_addr),
        .dbg_data_recv    (dbg_data_recv)
    );

    typedef struct {
        logic [9:0] src;
        logic [9:0] dst;
        int         tag;
        int         pulse;
    } vec_t;

    vec_t vec [13];

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got hi=%0h lo=%0h expected hi=%0h lo=%0h",
                     name, act[1023:960], act[63:0], exp[1023:960], exp[63:0]);
        end
    endtask

    function automatic logic [1023:0] pat(input int k);
        return {32{32'hA500_0000 | 32'(k)}};
    endfunction

    // One full transfer from IDLE, checking every TX beat, latency and the debug outputs.
    task automatic xfer(input logic [9:0] s, input logic [9:0] d, input logic [1023:0] exp_w,
                        input int pulse_at, input string tag);
        int lat;
        router_scr_addr  = s;
        router_dst_addr  = d;
        router_start_req = 1'b1;
        tick();
        router_start_req = 1'b0;
        chk($sformatf("%s done_fall", tag), 128'(router_done), 128'd0);
        tick();
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("%s beat%0d_valid", tag, b), 128'(lane_tx_valid), 128'hF);
            chk($sformatf("%s beat%0d_data", tag, b), lane_tx_data, exp_w[b*128 +: 128]);
            if (b == pulse_at) begin
                router_start_req = 1'b1;
                router_scr_addr  = 10'd1;
                router_dst_addr  = 10'd2;
            end
            tick();
            router_start_req = 1'b0;
        end
        chk($sformatf("%s valid_off", tag), 128'(lane_tx_valid), 128'd0);
        lat = 9;
        while (!router_done && lat < 100) begin
            tick();
            lat++;
        end
        chk($sformatf("%s latency", tag), 128'(lat), 128'd11);
        chk($sformatf("%s dbg_dst", tag), 128'(dbg_dst_addr), 128'(d));
        chk_w($sformatf("%s dbg_data", tag), dbg_data_recv, exp_w);
        tick();
    endtask

    initial begin
        logic [1023:0] w;
        int            n;

        vec[0]  = '{10'd5,     10'd15,    5, -1};
        vec[1]  = '{10'd0,     10'd9,     0, -1};
        vec[2]  = '{10'd1,     10'd5,     1, -1};
        vec[3]  = '{10'd2,     10'd15,    2, -1};
        vec[4]  = '{10'd3,     10'd5,     3, -1};
        vec[5]  = '{10'd4,     10'd9,     4, -1};
        vec[6]  = '{10'd9,     10'd1,     4, -1};
        vec[7]  = '{10'd7,     10'd7,     7, -1};
        vec[8]  = '{10'h3F3,   10'h00A,   3, -1};
        vec[9]  = '{10'h01A,   10'h00C,   3, -1};
        vec[10] = '{10'd1,     10'd0,     4, -1};
        vec[11] = '{10'd6,     10'd11,    6,  3};
        vec[12] = '{10'd2,     10'd8,     2, -1};

        rst_n            = 1'b0;
        router_start_req = 1'b0;
        router_scr_addr  = '0;
        router_dst_addr  = '0;

        // Reset state
        tick();
        tick();
        chk("rst done", 128'(router_done), 128'd0);
        chk("rst tx_valid", 128'(lane_tx_valid), 128'd0);
        chk("rst tx_data", lane_tx_data, 128'd0);
        chk("rst dbg_dst", 128'(dbg_dst_addr), 128'd0);
        chk_w("rst dbg_data", dbg_data_recv, '0);

        // INIT window: done low for 15 edges after release, high from the 16th
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("init done@%0d", i), 128'(router_done), 128'(i >= 16));
            chk($sformatf("init tx_valid@%0d", i), 128'(lane_tx_valid), 128'd0);
        end

        // Transfer table
        for (int r = 0; r < 13; r++) begin
            xfer(vec[r].src, vec[r].dst, pat(vec[r].tag), vec[r].pulse, $sformatf("row%0d", r));
        end

        // Lane 2 invalid on beat 3: beat dropped, block parks in WAIT_RX until an extra beat
        router_scr_addr  = 10'd7;
        router_dst_addr  = 10'd13;
        router_start_req = 1'b1;
        tick();
        router_start_req = 1'b0;
        tick();
        tick();
        tick();
        tick();
        valid_mask = 4'b1011;
        tick();
        valid_mask = 4'hF;
        for (int i = 0; i < 20; i++) tick();
        chk("drop done_held_low", 128'(router_done), 128'd0);
        chk("drop tx_idle", 128'(lane_tx_valid), 128'd0);
        ovr_data    = {4{32'hDEAD_BEEF}};
        rx_override = 1'b1;
        tick();
        rx_override = 1'b0;
        n = 0;
        while (!router_done && n < 50) begin
            tick();
            n++;
        end
        chk("drop extra_beat_latency", 128'(n), 128'd2);
        w = pat(7);
        w[1023:896] = {4{32'hDEAD_BEEF}};
        chk("drop dbg_dst", 128'(dbg_dst_addr), 128'd13);
        chk_w("drop dbg_data", dbg_data_recv, w);
        tick();

        // Non-uniform word proves beat ordering on the TX side
        xfer(10'd13, 10'd14, w, -1, "mixed");

        // Reset at beat 4 of SEND aborts the write to address 3
        router_scr_addr  = 10'd0;
        router_dst_addr  = 10'd3;
        router_start_req = 1'b1;
        tick();
        router_start_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort done", 128'(router_done), 128'd0);
        chk("abort tx_valid", 128'(lane_tx_valid), 128'd0);
        chk("abort tx_data", lane_tx_data, 128'd0);
        chk("abort dbg_dst", 128'(dbg_dst_addr), 128'd0);
        chk_w("abort dbg_data", dbg_data_recv, '0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!router_done && n < 50) begin
            tick();
            n++;
        end
        chk("abort reinit_cycles", 128'(n), 128'd16);
        xfer(10'd3, 10'd4, pat(3), -1, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
